// File: rtl/ripple_down_monitor.sv
// Consumer of the asynchronous ripple down counter: synchronises and debounces
// the raw count, accepts stable values, and checks that each accepted step is a decrement by one.
module ripple_down_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              valid_out,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic              err_sticky,
  output logic              seeded
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0]  ONES     = '1;

  typedef enum logic {SEED, TRACK} state_e;

  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_out_q, cnt_out_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0]  dec_val;
  logic              accept;

  assign dec_val = cnt_out_q - WIDTH'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    cand_d = cand_q;
    stab_d = stab_q;
    accept = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = STAB_W'(1);
      accept = (STAB_MAX == STAB_W'(1));
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
      accept = (stab_d == STAB_MAX);
    end
    // clr freezes the candidate and discards any coincident accept.
    if (clr) begin
      cand_d = cand_q;
      stab_d = '0;
      accept = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_out_d  = cnt_out_q;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    sticky_d   = sticky_q;
    wrap_cnt_d = wrap_cnt_q;
    if (clr) begin
      state_d    = SEED;
      sticky_d   = 1'b0;
      wrap_cnt_d = '0;
    end else if (accept) begin
      unique case (state_q)
        SEED: begin
          cnt_out_d = sync2_q;
          valid_d   = 1'b1;
          state_d   = TRACK;
        end
        TRACK: begin
          // A value equal to the current output is a glitch that settled back.
          if (sync2_q != cnt_out_q) begin
            cnt_out_d = sync2_q;
            valid_d   = 1'b1;
            if (sync2_q == dec_val) begin
              if (cnt_out_q == '0) begin
                wrap_d     = 1'b1;
                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
              end
            end else begin
              err_d    = 1'b1;
              sticky_d = 1'b1;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= ONES;
      sync2_q    <= ONES;
      cand_q     <= ONES;
      stab_q     <= '0;
      state_q    <= SEED;
      cnt_out_q  <= ONES;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      sync1_q    <= cnt_in;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      stab_q     <= stab_d;
      state_q    <= state_d;
      cnt_out_q  <= cnt_out_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign cnt_out    = cnt_out_q;
  assign valid_out  = valid_q;
  assign wrap_pulse = wrap_q;
  assign wrap_count = wrap_cnt_q;
  assign step_err   = err_q;
  assign err_sticky = sticky_q;
  assign seeded     = (state_q == TRACK);

endmodule

// File: tb/tb_ripple_down_monitor.sv
// Scoreboard bench for ripple_down_monitor: stimulus pushes expected accepts,
// a negedge monitor pops and compares whenever valid_out pulses.
module tb_ripple_down_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] cnt_in;
  logic [3:0] cnt_out;
  logic       valid_out, wrap_pulse, step_err, err_sticky, seeded;
  logic [7:0] wrap_count;

  typedef struct {
    logic [3:0] cnt;
    bit         wrap;
    bit         err;
    int         cyc;   // sampling cycle the pulse must appear in, -1 = any
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  ripple_down_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cnt_in     (cnt_in),
    .cnt_out    (cnt_out),
    .valid_out  (valid_out),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .seeded     (seeded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented output pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_valid: cnt_out=%0h err=%0b wrap=%0b, expected no pulse (cycle %0d)",
                   cnt_out, step_err, wrap_pulse, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_cnt_out", 32'(cnt_out), 32'(e.cnt));
          check("sb_wrap_pulse", 32'(wrap_pulse), 32'(e.wrap));
          check("sb_step_err", 32'(step_err), 32'(e.err));
          check("sb_seeded", 32'(seeded), 32'd1);
          if (e.cyc >= 0) check("sb_latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (wrap_pulse || step_err) begin
        tests++;
        failed++;
        $display("FAIL stray_pulse: wrap=%0b err=%0b without valid_out, expected 0 (cycle %0d)",
                 wrap_pulse, step_err, cyc);
      end
    end
  end

  // Called on a negedge: the change reaches s1 on the next edge, so the
  // accept pulse is sampled four edges later.
  task automatic step(input logic [3:0] v, input bit exp_v, input bit w, input bit e, input int hold);
    if (exp_v) sb.push_back('{v, w, e, cyc + 4});
    cnt_in = v;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    cnt_in = 4'hF;
    repeat (3) @(negedge clk);

    // 1: reset values, then seeding with F held
    check("rst_cnt_out", 32'(cnt_out), 32'hF);
    check("rst_seeded", 32'(seeded), 32'd0);
    check("rst_wrap_count", 32'(wrap_count), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    rst = 1'b0;
    sb.push_back('{4'hF, 1'b0, 1'b0, -1});
    repeat (6) @(negedge clk);
    check("seed_seeded", 32'(seeded), 32'd1);
    check("seed_cnt_out", 32'(cnt_out), 32'hF);

    // 2: clean decrements
    step(4'hE, 1, 0, 0, 6);
    step(4'hD, 1, 0, 0, 6);
    check("dec_cnt_out", 32'(cnt_out), 32'hD);
    check("dec_sticky", 32'(err_sticky), 32'd0);

    // 3: count down to 0, then 257 wraps (wrap_count passes through 0 at 256)
    for (int v = 12; v >= 0; v--) step(4'(v), 1, 0, 0, 5);
    for (int k = 1; k <= 257; k++) begin
      step(4'hF, 1, 1, 0, 5);
      if (k == 1 || k >= 256) check($sformatf("wrap_count_%0d", k), 32'(wrap_count), 32'(k % 256));
      if (k < 257) for (int v = 14; v >= 0; v--) step(4'(v), 1, 0, 0, 5);
    end
    check("wrap_sticky", 32'(err_sticky), 32'd0);

    // 4: skip E->C flags an error, tracking continues
    step(4'hE, 1, 0, 0, 6);
    step(4'hC, 1, 0, 1, 6);
    check("skip_sticky", 32'(err_sticky), 32'd1);
    check("skip_cnt_out", 32'(cnt_out), 32'hC);
    step(4'hB, 1, 0, 0, 6);
    check("skip_sticky_held", 32'(err_sticky), 32'd1);

    // 5: short glitch filtered; long glitch accepted twice as errors
    for (int v = 10; v >= 7; v--) step(4'(v), 1, 0, 0, 6);
    step(4'h0, 0, 0, 0, 1);
    step(4'h7, 0, 0, 0, 6);
    check("glitch_cnt_out", 32'(cnt_out), 32'h7);
    step(4'h0, 1, 0, 1, 3);
    step(4'h7, 1, 0, 1, 6);
    check("glitch_back_cnt_out", 32'(cnt_out), 32'h7);

    // 6a: clr on the accept edge of 6
    cnt_in = 4'h6;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_seeded", 32'(seeded), 32'd0);
    check("clr_wrap_count", 32'(wrap_count), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_cnt_out_kept", 32'(cnt_out), 32'h7);
    sb.push_back('{4'h6, 1'b0, 1'b0, cyc + 2});
    repeat (6) @(negedge clk);
    check("reseed_seeded", 32'(seeded), 32'd1);
    check("reseed_cnt_out", 32'(cnt_out), 32'h6);

    // 6b: async reset while the filter is counting
    cnt_in = 4'h5;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt_out", 32'(cnt_out), 32'hF);
    check("arst_seeded", 32'(seeded), 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_step_err", 32'(step_err), 32'd0);
    check("arst_wrap_pulse", 32'(wrap_pulse), 32'd0);
    check("arst_sticky", 32'(err_sticky), 32'd0);
    cnt_in = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{4'hF, 1'b0, 1'b0, -1});
    repeat (6) @(negedge clk);
    check("rerun_seeded", 32'(seeded), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
